// File: rtl/aes_round_controller.sv
// Purpose : sequences one AES-128 block encryption through an external combinational aes_operations_unit.
// Latency : done pulses 51 cycles after the edge that accepts start; one block per 52 cycles back-to-back.
// Backpress: start is only sampled in IDLE; requests while busy (including DONE) are dropped, not queued.
//
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   start                 - begin encryption of block_in under key_in
//   block_in, key_in      - plaintext / cipher key, word 0 = bytes 0..3
//   busy, done            - FSM not idle / one-cycle completion pulse
//   block_out             - ciphertext, held until the next completion
//   round                 - current round number 0..10
//   op_select, op_a, op_b - operation and operands driven to the unit
//   op_result             - combinational result returned by the unit
module aes_round_controller #(
    parameter int regSize = 32,
    parameter int vecSize = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [vecSize-1:0][regSize-1:0]  block_in,
    input  logic [vecSize-1:0][regSize-1:0]  key_in,
    output logic                             busy,
    output logic                             done,
    output logic [vecSize-1:0][regSize-1:0]  block_out,
    output logic [3:0]                       round,
    output logic [2:0]                       op_select,
    output logic [vecSize-1:0][regSize-1:0]  op_a,
    output logic [vecSize-1:0][regSize-1:0]  op_b,
    input  logic [vecSize-1:0][regSize-1:0]  op_result
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_INIT_ARK = 3'd1;
    localparam logic [2:0] ST_KEYEXP   = 3'd2;
    localparam logic [2:0] ST_SUB      = 3'd3;
    localparam logic [2:0] ST_SHIFT    = 3'd4;
    localparam logic [2:0] ST_MIX      = 3'd5;
    localparam logic [2:0] ST_ARK      = 3'd6;
    localparam logic [2:0] ST_DONE     = 3'd7;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_KEXP  = 3'b001;
    localparam logic [2:0] OP_SUB   = 3'b010;
    localparam logic [2:0] OP_SHIFT = 3'b011;
    localparam logic [2:0] OP_MIX   = 3'b100;
    localparam logic [2:0] OP_ARK   = 3'b101;

    localparam logic [3:0] LAST_ROUND = 4'd10;

    logic [2:0]                       r_fsm;
    logic [vecSize-1:0][regSize-1:0]  r_state;
    logic [vecSize-1:0][regSize-1:0]  r_key;
    logic [3:0]                       r_round;
    logic [vecSize-1:0][regSize-1:0]  r_block_out;

    logic [vecSize-1:0][regSize-1:0]  w_round_vec;
    logic                             w_last_round;

    assign w_last_round = (r_round == LAST_ROUND);

    // KeyExpansion takes the round number replicated into every word; the
    // unit derives Rcon from it.
    always_comb begin
        w_round_vec = '0;
        for (int i = 0; i < vecSize; i++) begin
            w_round_vec[i] = {{(regSize-4){1'b0}}, r_round};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm       <= ST_IDLE;
            r_state     <= '0;
            r_key       <= '0;
            r_round     <= '0;
            r_block_out <= '0;
        end else begin
            case (r_fsm)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= block_in;
                        r_key   <= key_in;
                        r_round <= '0;
                        r_fsm   <= ST_INIT_ARK;
                    end
                end
                ST_INIT_ARK: begin
                    r_state <= op_result;
                    r_round <= 4'd1;
                    r_fsm   <= ST_KEYEXP;
                end
                ST_KEYEXP: begin
                    r_key <= op_result;
                    r_fsm <= ST_SUB;
                end
                ST_SUB: begin
                    r_state <= op_result;
                    r_fsm   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    r_state <= op_result;
                    // The final round skips MixColumns.
                    r_fsm   <= w_last_round ? ST_ARK : ST_MIX;
                end
                ST_MIX: begin
                    r_state <= op_result;
                    r_fsm   <= ST_ARK;
                end
                ST_ARK: begin
                    if (!w_last_round) begin
                        r_state <= op_result;
                        r_round <= r_round + 4'd1;
                        r_fsm   <= ST_KEYEXP;
                    end else begin
                        // Final AddRoundKey goes straight to the output
                        // register; state_reg is left as is.
                        r_block_out <= op_result;
                        r_fsm       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_fsm <= ST_IDLE;
                end
                default: begin
                    r_fsm <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        op_select = OP_NOP;
        op_a      = '0;
        op_b      = '0;
        case (r_fsm)
            ST_INIT_ARK, ST_ARK: begin
                op_select = OP_ARK;
                op_a      = r_state;
                op_b      = r_key;
            end
            ST_KEYEXP: begin
                op_select = OP_KEXP;
                op_a      = r_key;
                op_b      = w_round_vec;
            end
            ST_SUB: begin
                op_select = OP_SUB;
                op_a      = r_state;
            end
            ST_SHIFT: begin
                op_select = OP_SHIFT;
                op_a      = r_state;
            end
            ST_MIX: begin
                op_select = OP_MIX;
                op_a      = r_state;
            end
            default: begin
                op_select = OP_NOP;
            end
        endcase
    end

    assign busy      = (r_fsm != ST_IDLE);
    assign done      = (r_fsm == ST_DONE);
    assign round     = r_round;
    assign block_out = r_block_out;

endmodule

// File: tb/tb_aes_round_controller.sv
// Bench for aes_round_controller: models the combinational AES operations unit,
// checks op trace, key-expansion operands, known-answer and random blocks,
// held-start behaviour and asynchronous reset.
module tb_aes_round_controller;

    typedef logic [3:0][31:0] vec_t;
    typedef struct {
        vec_t pt;
        vec_t key;
        vec_t ct;
    } vec_rec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    vec_t       block_in, key_in, block_out, op_a, op_b, op_result;
    logic       busy, done;
    logic [3:0] round;
    logic [2:0] op_select;

    int vectors     = 0;
    int miscompares = 0;
    int exp_ops[51];
    int exp_rnd[51];

    always #5 clk = ~clk;

    aes_round_controller #(.regSize(32), .vecSize(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .block_in  (block_in),
        .key_in    (key_in),
        .busy      (busy),
        .done      (done),
        .block_out (block_out),
        .round     (round),
        .op_select (op_select),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_result (op_result)
    );

    // ---------------- AES byte-level primitives ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [7:0] t;
        t = (x << n) | (x >> (8 - n));
        return t;
    endfunction

    // S-box from first principles: multiplicative inverse (x^254) then affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p, r;
        p = x;
        r = 8'h01;
        for (int k = 1; k < 8; k++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        if (x == 8'h00) r = 8'h00;
        return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] gb(input vec_t v, input int b);
        return v[b/4][31-8*(b%4) -: 8];
    endfunction

    function automatic vec_t sb(input vec_t v, input int b, input logic [7:0] x);
        v[b/4][31-8*(b%4) -: 8] = x;
        return v;
    endfunction

    function automatic vec_t mkv(input logic [31:0] w0, input logic [31:0] w1,
                                 input logic [31:0] w2, input logic [31:0] w3);
        vec_t v;
        v[0] = w0; v[1] = w1; v[2] = w2; v[3] = w3;
        return v;
    endfunction

    function automatic vec_t sub_bytes(input vec_t v);
        vec_t o = '0;
        for (int b = 0; b < 16; b++) o = sb(o, b, sbox(gb(v, b)));
        return o;
    endfunction

    function automatic vec_t shift_rows(input vec_t v);
        vec_t o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o = sb(o, r + 4*c, gb(v, r + 4*((c + r) % 4)));
        return o;
    endfunction

    function automatic vec_t mix_cols(input vec_t v);
        vec_t o = '0;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = gb(v, 4*c); a1 = gb(v, 4*c+1); a2 = gb(v, 4*c+2); a3 = gb(v, 4*c+3);
            o = sb(o, 4*c,   gmul(a0,2) ^ gmul(a1,3) ^ a2 ^ a3);
            o = sb(o, 4*c+1, a0 ^ gmul(a1,2) ^ gmul(a2,3) ^ a3);
            o = sb(o, 4*c+2, a0 ^ a1 ^ gmul(a2,2) ^ gmul(a3,3));
            o = sb(o, 4*c+3, gmul(a0,3) ^ a1 ^ a2 ^ gmul(a3,2));
        end
        return o;
    endfunction

    function automatic vec_t key_exp(input vec_t k, input int r);
        logic [7:0]  rc = 8'h01;
        logic [31:0] t;
        vec_t        n;
        for (int i = 1; i < r; i++) rc = xt(rc);
        t = {k[3][23:0], k[3][31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
        n[0] = k[0] ^ t;
        n[1] = k[1] ^ n[0];
        n[2] = k[2] ^ n[1];
        n[3] = k[3] ^ n[2];
        return n;
    endfunction

    // Behavioural stand-in for aes_operations_unit.
    function automatic vec_t unit_model(input logic [2:0] op, input vec_t a, input vec_t b);
        case (op)
            3'b001:  return key_exp(a, int'(b[0][3:0]));
            3'b010:  return sub_bytes(a);
            3'b011:  return shift_rows(a);
            3'b100:  return mix_cols(a);
            3'b101:  return a ^ b;
            default: return '0;
        endcase
    endfunction

    function automatic vec_t aes_ref(input vec_t pt, input vec_t key);
        vec_t s = pt ^ key;
        vec_t k = key;
        for (int r = 1; r <= 10; r++) begin
            k = key_exp(k, r);
            s = shift_rows(sub_bytes(s));
            if (r < 10) s = mix_cols(s);
            s = s ^ k;
        end
        return s;
    endfunction

    always_comb op_result = unit_model(op_select, op_a, op_b);

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},      128'(busy),      128'(0));
        chk({tag, "_done"},      128'(done),      128'(0));
        chk({tag, "_round"},     128'(round),     128'(0));
        chk({tag, "_op_select"}, 128'(op_select), 128'(0));
        chk({tag, "_op_a"},      op_a,            128'(0));
        chk({tag, "_op_b"},      op_b,            128'(0));
        chk({tag, "_block_out"}, block_out,       128'(0));
    endtask

    // Launch one block; returns captured block_out. Inputs are scrambled
    // right after acceptance to show they are not resampled.
    task automatic run_block(input vec_t pt, input vec_t key, input bit trace, output vec_t ct);
        int   c;
        bit   seen;
        vec_t kexp;
        @(negedge clk);
        block_in = pt; key_in = key; start = 1'b1;
        @(negedge clk);
        start = 1'b0; block_in = ~pt; key_in = ~key;
        c = 1; seen = 1'b0; kexp = key; ct = '0;
        while (!seen && c <= 60) begin
            if (trace && c <= 51) begin
                chk("op_trace",    128'(op_select), 128'(exp_ops[c-1]));
                chk("round_trace", 128'(round),     128'(exp_rnd[c-1]));
                chk("done_trace",  128'(done),      128'(c == 51));
                chk("busy_trace",  128'(busy),      128'(1));
                if (exp_ops[c-1] == 1) begin
                    chk("kexp_op_a", op_a, kexp);
                    chk("kexp_op_b", op_b, mkv(32'(exp_rnd[c-1]), 32'(exp_rnd[c-1]),
                                               32'(exp_rnd[c-1]), 32'(exp_rnd[c-1])));
                    kexp = key_exp(kexp, exp_rnd[c-1]);
                end
            end
            if (done) begin
                seen = 1'b1;
                chk("done_cycle", 128'(c), 128'(51));
                ct = block_out;
            end else begin
                @(negedge clk);
                c++;
            end
        end
        if (!seen) chk("done_timeout", 128'(0), 128'(1));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vec_rec_t tbl[2];
        vec_t     ct, pa, ka, pb, kb, ref_a;
        int       n, c;
        bit       held;

        rst = 1'b0; start = 1'b0; block_in = '0; key_in = '0;

        // Expected op/round trace derived from the round structure.
        n = 0;
        exp_ops[n] = 5; exp_rnd[n] = 0; n++;
        for (int r = 1; r <= 10; r++) begin
            exp_ops[n] = 1; exp_rnd[n] = r; n++;
            exp_ops[n] = 2; exp_rnd[n] = r; n++;
            exp_ops[n] = 3; exp_rnd[n] = r; n++;
            if (r < 10) begin exp_ops[n] = 4; exp_rnd[n] = r; n++; end
            exp_ops[n] = 5; exp_rnd[n] = r; n++;
        end
        exp_ops[n] = 0; exp_rnd[n] = 10;

        tbl[0].pt  = mkv(32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff);
        tbl[0].key = mkv(32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f);
        tbl[0].ct  = mkv(32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a);
        tbl[1].pt  = mkv(32'h3243f6a8, 32'h885a308d, 32'h313198a2, 32'he0370734);
        tbl[1].key = mkv(32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c);
        tbl[1].ct  = mkv(32'h3925841d, 32'h02dc09fb, 32'hdc118597, 32'h196a0b32);

        // Reset asserted mid-cycle: outputs clear without a clock edge.
        #2 rst = 1'b1;
        #1 chk_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("busy_after_reset", 128'(busy), 128'(0));

        // Known-answer table; first entry also checks the full op trace.
        for (int i = 0; i < 2; i++) begin
            run_block(tbl[i].pt, tbl[i].key, (i == 0), ct);
            chk("kat_ct", ct, tbl[i].ct);
        end

        // Random blocks against the reference model.
        for (int i = 0; i < 6; i++) begin
            pa = mkv($urandom, $urandom, $urandom, $urandom);
            ka = mkv($urandom, $urandom, $urandom, $urandom);
            run_block(pa, ka, 1'b0, ct);
            chk("rand_ct", ct, aes_ref(pa, ka));
        end

        // start held high across two blocks.
        pa = mkv($urandom, $urandom, $urandom, $urandom);
        ka = mkv($urandom, $urandom, $urandom, $urandom);
        pb = mkv($urandom, $urandom, $urandom, $urandom);
        kb = mkv($urandom, $urandom, $urandom, $urandom);
        ref_a = aes_ref(pa, ka);
        @(negedge clk);
        block_in = pa; key_in = ka; start = 1'b1;
        @(negedge clk);
        block_in = pb; key_in = kb;
        c = 1;
        while (!done && c < 60) begin @(negedge clk); c++; end
        chk("held_first_done_cycle", 128'(c), 128'(51));
        chk("held_first_ct", block_out, ref_a);
        @(negedge clk);
        chk("held_idle_busy", 128'(busy), 128'(0));
        chk("held_idle_done", 128'(done), 128'(0));
        @(negedge clk);
        chk("held_accept_busy", 128'(busy), 128'(1));
        chk("held_accept_op", 128'(op_select), 128'(5));
        start = 1'b0;
        c = 1; held = 1'b1;
        while (!done && c < 60) begin
            held = held & (block_out === ref_a);
            @(negedge clk);
            c++;
        end
        chk("held_block_out_kept", 128'(held), 128'(1));
        chk("held_second_done_cycle", 128'(c), 128'(51));
        chk("held_second_ct", block_out, aes_ref(pb, kb));

        // Reset in the middle of round 5.
        @(negedge clk);
        block_in = tbl[1].pt; key_in = tbl[1].key; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 0;
        while (round != 4'd5 && c < 60) begin @(negedge clk); c++; end
        chk("midreset_reached_round5", 128'(round), 128'(5));
        #2 rst = 1'b1;
        #1 chk_zero("midreset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midreset_idle_busy", 128'(busy), 128'(0));
        run_block(tbl[0].pt, tbl[0].key, 1'b1, ct);
        chk("midreset_fresh_ct", ct, tbl[0].ct);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
